d_sramlike_bridge: RTL and testbench

Data-side memory bridge sitting directly downstream of the MIPS datapath memory stage. Converts the datapath's single-cycle data SRAM port (enable, byte-write mask, address, write data, read data) into a split-transaction SRAM-like handshake: request accepted on `addr_ok`, completion on `data_ok`. Generates `d_stall` to freeze the pipeline until the access completes, and holds the result until the whole pipeline (`all_stall`) releases.

---
 rtl/d_sramlike_pkg.sv | 16 +
 rtl/d_sramlike_size.sv | 36 +++
 rtl/d_sramlike_bridge.sv | 129 ++++++++++++
 tb/tb_d_sramlike_bridge.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/d_sramlike_pkg.sv
// d_sramlike_pkg: shared encodings for the data-side SRAM-like bridge.
// Holds the bridge FSM state encoding and the SRAM-like transfer size codes.
package d_sramlike_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,  // no access in flight
        ST_ADDR = 2'd1,  // request presented, waiting for addr_ok
        ST_DATA = 2'd2,  // request accepted, waiting for data_ok
        ST_DONE = 2'd3   // result held until the pipeline releases
    } state_e;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/d_sramlike_size.sv
// d_sramlike_size: maps the datapath byte-write mask and byte address onto an
// SRAM-like transfer size and the address that transfer should carry.
// Loads are always whole-word reads; lane extraction happens in writeback.
module d_sramlike_size
    import d_sramlike_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [3:0]        wen_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic [1:0]        size_o,
    output logic [ADDR_W-1:0] addr_o
);

    logic [1:0] lane;

    // Decode mask into size and low address bits; irregular masks fall back to word.
    // NOTE: size_o and lane are given defaults first so no path through the case leaves them unassigned (which would infer a latch).
    always_comb begin
        size_o = SIZE_WORD;
        lane   = 2'b00;
        case (wen_i)
            4'b0000: begin size_o = SIZE_WORD; lane = 2'b00; end
            4'b1111: begin size_o = SIZE_WORD; lane = 2'b00; end
            4'b0011: begin size_o = SIZE_HALF; lane = 2'b00; end
            4'b1100: begin size_o = SIZE_HALF; lane = 2'b10; end
            4'b0001: begin size_o = SIZE_BYTE; lane = 2'b00; end
            4'b0010: begin size_o = SIZE_BYTE; lane = 2'b01; end
            4'b0100: begin size_o = SIZE_BYTE; lane = 2'b10; end
            4'b1000: begin size_o = SIZE_BYTE; lane = 2'b11; end
            default: begin size_o = SIZE_WORD; lane = 2'b00; end
        endcase
        addr_o = {addr_i[ADDR_W-1:2], lane};
    end

endmodule

// File: rtl/d_sramlike_bridge.sv
// d_sramlike_bridge: turns the datapath's single-cycle data SRAM port into a
// split-transaction SRAM-like request (addr_ok) / response (data_ok) pair,
// stalling the pipeline until the access completes and holding the load
// result until the whole pipeline is released.
// Optional build macro: D_BRIDGE_PERF_EN adds perf_req_cnt / perf_stall_cnt.
module d_sramlike_bridge
    import d_sramlike_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    // datapath side
    input  logic              data_sram_en,
    input  logic [3:0]        data_sram_wen,
    input  logic [ADDR_W-1:0] data_sram_addr,
    input  logic [DATA_W-1:0] data_sram_wdata,
    output logic [DATA_W-1:0] data_sram_rdata,
    output logic              d_stall,
    input  logic              all_stall,
    // SRAM-like side
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [ADDR_W-1:0] data_addr,
    output logic [DATA_W-1:0] data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [DATA_W-1:0] data_rdata
`ifdef D_BRIDGE_PERF_EN
    ,
    output logic [31:0]       perf_req_cnt,
    output logic [31:0]       perf_stall_cnt
`endif
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              capture;

    d_sramlike_size #(.ADDR_W(ADDR_W)) u_size (
        .wen_i  (data_sram_wen),
        .addr_i (data_sram_addr),
        .size_o (data_size),
        .addr_o (data_addr)
    );

    // Request is driven straight from the datapath so the first cycle of an access can already be accepted.
    assign data_req        = data_sram_en & ((state_q == ST_IDLE) | (state_q == ST_ADDR));
    assign data_wr         = |data_sram_wen;
    assign data_wdata      = data_sram_wdata;
    assign d_stall         = data_sram_en & (state_q != ST_DONE);
    assign data_sram_rdata = result_q;

    // Next-state and result capture; a flushed access drains its response without reaching DONE.
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        capture  = 1'b0;
        case (state_q)
            ST_IDLE, ST_ADDR: begin
                if (!data_sram_en) begin
                    state_d = ST_IDLE;
                end else if (data_addr_ok && data_data_ok) begin
                    state_d = ST_DONE;
                    capture = 1'b1;
                end else if (data_addr_ok) begin
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_ADDR;
                end
            end
            ST_DATA: begin
                if (data_data_ok) begin
                    if (data_sram_en) begin
                        state_d = ST_DONE;
                        capture = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DONE: begin
                if (!all_stall) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (capture) result_d = data_rdata;
    end

    // State and result registers with synchronous reset.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
        end
    end

`ifdef D_BRIDGE_PERF_EN
    logic [31:0] perf_req_q, perf_req_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    // Completed-transaction and stall-cycle counters; both wrap naturally.
    always_comb begin
        perf_req_d   = perf_req_q + {31'd0, capture};
        perf_stall_d = perf_stall_q + {31'd0, d_stall};
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_req_q   <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_req_q   <= perf_req_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_req_cnt   = perf_req_q;
    assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_d_sramlike_bridge.sv
// tb_d_sramlike_bridge: self-checking bench for d_sramlike_bridge.
// A small SRAM-like slave answers each access with configurable addr_ok /
// data_ok delays; expected results are queued at issue and popped on completion.
module tb_d_sramlike_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic        d_stall;
    logic        all_stall;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
`ifdef D_BRIDGE_PERF_EN
    logic [31:0] perf_req_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] sb_q[$];
    logic [31:0] last_result = 32'd0;

    always #5 clk = ~clk;

    d_sramlike_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .data_sram_rdata (data_sram_rdata),
        .d_stall         (d_stall),
        .all_stall       (all_stall),
        .data_req        (data_req),
        .data_wr         (data_wr),
        .data_size       (data_size),
        .data_addr       (data_addr),
        .data_wdata      (data_wdata),
        .data_addr_ok    (data_addr_ok),
        .data_data_ok    (data_data_ok),
        .data_rdata      (data_rdata)
`ifdef D_BRIDGE_PERF_EN
        ,
        .perf_req_cnt    (perf_req_cnt),
        .perf_stall_cnt  (perf_stall_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One full access: issue, slave handshake, DONE hold under all_stall, release.
    task automatic do_txn(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] rdata,
                          input int a_dly, input int d_dly, input int hold,
                          input logic [1:0] exp_size, input logic [31:0] exp_addr);
        int          cyc       = 0;
        int          stall_cnt = 0;
        bit          accepted  = 0;
        bit          finished  = 0;
        logic [31:0] wdata     = $urandom;
        logic [31:0] exp_r;

        data_sram_en    = 1'b1;
        data_sram_wen   = wen;
        data_sram_addr  = addr;
        data_sram_wdata = wdata;
        all_stall       = 1'b1;
        sb_q.push_back(rdata);

        while (!finished && cyc < 64) begin
            data_addr_ok = !accepted && (cyc == a_dly);
            data_data_ok = (accepted || data_addr_ok) && (cyc == a_dly + d_dly);
            data_rdata   = data_data_ok ? rdata : (32'hBAD0_0000 | cyc);
            @(negedge clk);
            if (!accepted) begin
                check("req", data_req, 1);
                check("size", data_size, exp_size);
                check("addr", data_addr, exp_addr);
                check("wr", data_wr, |wen);
                check("wdata", data_wdata, wdata);
            end else begin
                check("req_after_accept", data_req, 0);
            end
            if (d_stall) stall_cnt++;
            if (data_addr_ok) accepted = 1;
            finished = data_data_ok;
            next_cycle();
            cyc++;
        end
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        if (!finished) check("txn_timeout", 1, 0);
        check("stall_cycles", stall_cnt, a_dly + d_dly + 1);

        if (sb_q.size() == 0) begin
            check("sb_empty", 1, 0);
            exp_r = 32'd0;
        end else begin
            exp_r = sb_q.pop_front();
        end
        last_result = exp_r;

        for (int i = 0; i <= hold; i++) begin
            all_stall = (i < hold);
            @(negedge clk);
            check("done_req", data_req, 0);
            check("done_stall", d_stall, 0);
            check("done_rdata", data_sram_rdata, exp_r);
            next_cycle();
        end
        data_sram_en = 1'b0;
        @(negedge clk);
        check("idle_rdata", data_sram_rdata, exp_r);
        check("idle_req", data_req, 0);
        next_cycle();
    endtask

    initial begin
        rst             = 1'b1;
        data_sram_en    = 1'b0;
        data_sram_wen   = 4'b0000;
        data_sram_addr  = 32'd0;
        data_sram_wdata = 32'd0;
        all_stall       = 1'b0;
        data_addr_ok    = 1'b0;
        data_data_ok    = 1'b0;
        data_rdata      = 32'd0;

        // Reset state
        repeat (2) next_cycle();
        @(negedge clk);
        check("rst_req", data_req, 0);
        check("rst_stall", d_stall, 0);
        check("rst_rdata", data_sram_rdata, 0);
        next_cycle();
        data_sram_en = 1'b1;
        @(negedge clk);
        check("rst_req_en", data_req, 1);
        check("rst_stall_en", d_stall, 1);
        next_cycle();
        rst          = 1'b0;
        data_sram_en = 1'b0;
        next_cycle();

        // Mask/address decode and handshake timing
        do_txn(4'b0000, 32'h0000_0100, 32'hDEAD_BEEF, 0, 0, 0, 2'd2, 32'h0000_0100);
        do_txn(4'b0100, 32'h0000_0203, 32'h0102_0304, 0, 3, 0, 2'd0, 32'h0000_0202);
        do_txn(4'b1100, 32'h0000_0040, 32'hCAFE_F00D, 5, 1, 3, 2'd1, 32'h0000_0042);
        do_txn(4'b0000, 32'h0000_0107, 32'h5555_AAAA, 2, 2, 1, 2'd2, 32'h0000_0104);
        do_txn(4'b1111, 32'h0000_0301, 32'h1111_2222, 1, 0, 0, 2'd2, 32'h0000_0300);
        do_txn(4'b0011, 32'h0000_0052, 32'h3333_4444, 0, 1, 0, 2'd1, 32'h0000_0050);
        do_txn(4'b1000, 32'h0000_0060, 32'h6666_7777, 0, 0, 2, 2'd0, 32'h0000_0063);
        do_txn(4'b0110, 32'h0000_0071, 32'h8888_9999, 1, 1, 0, 2'd2, 32'h0000_0070);
        do_txn(4'b0001, 32'h0000_0083, 32'hABCD_0001, 0, 0, 0, 2'd0, 32'h0000_0080);
        do_txn(4'b0010, 32'h0000_0090, 32'hABCD_0002, 0, 2, 0, 2'd0, 32'h0000_0091);

        // Flush while waiting for addr_ok
        data_sram_en   = 1'b1;
        data_sram_wen  = 4'b0000;
        data_sram_addr = 32'h0000_0400;
        @(negedge clk);
        check("flA_req", data_req, 1);
        next_cycle();
        data_sram_en = 1'b0;
        @(negedge clk);
        check("flA_req_off", data_req, 0);
        check("flA_stall", d_stall, 0);
        next_cycle();
        do_txn(4'b0000, 32'h0000_0404, 32'h0F0F_0F0F, 0, 0, 0, 2'd2, 32'h0000_0404);

        // Flush after acceptance: response drained and discarded
        data_sram_en   = 1'b1;
        data_sram_wen  = 4'b0000;
        data_sram_addr = 32'h0000_0500;
        data_addr_ok   = 1'b1;
        data_rdata     = 32'hBAD0_1111;
        @(negedge clk);
        check("flD_req", data_req, 1);
        next_cycle();
        data_addr_ok = 1'b0;
        data_sram_en = 1'b0;
        @(negedge clk);
        check("flD_req_off", data_req, 0);
        check("flD_stall", d_stall, 0);
        next_cycle();
        data_data_ok = 1'b1;
        data_rdata   = 32'h1234_5678;
        next_cycle();
        data_data_ok = 1'b0;
        @(negedge clk);
        check("flD_rdata", data_sram_rdata, last_result);
        next_cycle();
        do_txn(4'b1111, 32'h0000_0600, 32'h2468_ACE0, 0, 1, 0, 2'd2, 32'h0000_0600);

        // Reset while in DATA; stray data_ok afterwards
        data_sram_en   = 1'b1;
        data_sram_wen  = 4'b0000;
        data_sram_addr = 32'h0000_0700;
        data_addr_ok   = 1'b1;
        next_cycle();
        data_addr_ok = 1'b0;
        rst          = 1'b1;
        next_cycle();
        rst          = 1'b0;
        data_sram_en = 1'b0;
        data_data_ok = 1'b1;
        data_rdata   = 32'hFFFF_0000;
        last_result  = 32'd0;
        @(negedge clk);
        check("rstD_req", data_req, 0);
        check("rstD_rdata", data_sram_rdata, 0);
`ifdef D_BRIDGE_PERF_EN
        check("rstD_perf_req", perf_req_cnt, 0);
        check("rstD_perf_stall", perf_stall_cnt, 0);
`endif
        next_cycle();
        data_data_ok = 1'b0;
        @(negedge clk);
        check("rstD_stray", data_sram_rdata, 0);
        next_cycle();
        do_txn(4'b0000, 32'h0000_0800, 32'h7777_1234, 1, 1, 0, 2'd2, 32'h0000_0800);

        check("sb_drained", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
